// File: rtl/ram_rd_sched.sv
// Round-robin burst read scheduler: shares one synchronous RAM read port among
// NREQ FIFO fillers, issuing one read per cycle and routing tagged data back.
module ram_rd_sched #(
  parameter int unsigned REQ_W  = 2,
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned DW     = 24,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned NREQ  = 1 << REQ_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*RAM_AW-1:0]   req_addr,
  input  logic [NREQ*RAM_AW-1:0]   req_len,
  output logic [NREQ-1:0]          req_ready,
  output logic                     ram_ren,
  output logic [RAM_AW-1:0]        ram_raddr,
  input  logic [DW-1:0]            ram_rdata,
  output logic [NREQ-1:0]          fifo_wrreq,
  output logic [DW-1:0]            fifo_data,
  output logic                     fifo_last,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [REQ_W-1:0]         cur_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic [REQ_W-1:0]  rr_q, rr_d;
  logic [REQ_W-1:0]  cur_id_q, cur_id_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [RAM_AW-1:0] cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic [NREQ-1:0]   ready_q, ready_d;
  logic              ren_q, ren_d;
  logic              ren_last_q, ren_last_d;
  logic [RAM_AW-1:0] raddr_q, raddr_d;
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_last_q, tag_last_d;
  logic [NREQ-1:0]   wrreq_q, wrreq_d;
  logic [DW-1:0]     data_q, data_d;
  logic              last_q, last_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic              found;
  logic [REQ_W-1:0]  win;
  logic [REQ_W-1:0]  idx;
  logic [RAM_AW-1:0] win_len;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = rr_q + REQ_W'(i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    win_len = req_len[win*RAM_AW +: RAM_AW];

    state_d    = state_q;
    rr_d       = rr_q;
    cur_id_d   = cur_id_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    zero_d     = zero_q;
    ready_d    = '0;
    ren_d      = 1'b0;
    ren_last_d = 1'b0;
    raddr_d    = raddr_q;
    done_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          ready_d[win] = 1'b1;
          cur_id_d     = win;
          addr_d       = req_addr[win*RAM_AW +: RAM_AW];
          cnt_d        = win_len;
          zero_d       = (win_len == '0);
          rr_d         = win + 1'b1;
          state_d      = (win_len == '0) ? StDrain : StIssue;
        end
      end
      StIssue: begin
        ren_d      = 1'b1;
        raddr_d    = addr_q;
        ren_last_d = (cnt_q == RAM_AW'(1));
        addr_d     = addr_q + 1'b1;
        cnt_d      = cnt_q - 1'b1;
        if (cnt_q == RAM_AW'(1)) state_d = StDrain;
      end
      StDrain: begin
        // Zero-length bursts have no beats, so they finish right away.
        if (last_q || zero_q) begin
          state_d          = StIdle;
          done_d[cur_id_q] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    tag_vld_d  = (tag_vld_q << 1) | RD_LAT'(ren_q);
    tag_last_d = (tag_last_q << 1) | RD_LAT'(ren_q & ren_last_q);

    wrreq_d = '0;
    if (tag_vld_q[RD_LAT-1]) wrreq_d[cur_id_q] = 1'b1;
    last_d = tag_vld_q[RD_LAT-1] & tag_last_q[RD_LAT-1];
    data_d = tag_vld_q[RD_LAT-1] ? ram_rdata : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      cur_id_q   <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      ready_q    <= '0;
      ren_q      <= 1'b0;
      ren_last_q <= 1'b0;
      raddr_q    <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      wrreq_q    <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cur_id_q   <= cur_id_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      zero_q     <= zero_d;
      ready_q    <= ready_d;
      ren_q      <= ren_d;
      ren_last_q <= ren_last_d;
      raddr_q    <= raddr_d;
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
      wrreq_q    <= wrreq_d;
      data_q     <= data_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign req_ready  = ready_q;
  assign ram_ren    = ren_q;
  assign ram_raddr  = raddr_q;
  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = data_q;
  assign fifo_last  = last_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign cur_id     = cur_id_q;

endmodule

// File: tb/tb_ram_rd_sched.sv
// Scoreboard bench for ram_rd_sched: a timeline model predicts every grant,
// read, beat and done; a negedge monitor pops and compares against the DUT.
module tb_ram_rd_sched;
  localparam int REQ_W  = 2;
  localparam int NREQ   = 4;
  localparam int AW     = 8;
  localparam int DW     = 24;
  localparam int RD_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*AW-1:0]   req_len = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 ram_ren;
  logic [AW-1:0]        ram_raddr;
  logic [DW-1:0]        ram_rdata;
  logic [NREQ-1:0]      fifo_wrreq;
  logic [DW-1:0]        fifo_data;
  logic                 fifo_last;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [REQ_W-1:0]     cur_id;

  ram_rd_sched #(
    .REQ_W (REQ_W),
    .RAM_AW(AW),
    .DW    (DW),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .fifo_wrreq(fifo_wrreq),
    .fifo_data (fifo_data),
    .fifo_last (fifo_last),
    .done      (done),
    .busy      (busy),
    .cur_id    (cur_id)
  );

  always #5 clk = ~clk;

  // RAM model: garbage on cycles without a read so mistimed captures show up.
  logic [DW-1:0] mem  [256];
  logic [DW-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    pipe[0] <= ram_ren ? mem[ram_raddr] : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RD_LAT-1];

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t gq[$];
  ev_t rq[$];
  ev_t bq[$];
  ev_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  int          rr = 0;
  int          idle_from = 0;
  int          busy_lo = 0;
  int          busy_hi = 0;
  int          exp_cur = 0;
  int          g, base, len, gc, dc;
  bit          found;
  logic [31:0] e;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      e = 0;
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        e = 32'd1 << gq[0].a;
        exp_cur = gq[0].a;
        void'(gq.pop_front());
      end
      chk("req_ready", req_ready, e);
      chk("cur_id", cur_id, exp_cur);

      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        chk("ram_ren", ram_ren, 1);
        chk("ram_raddr", ram_raddr, rq[0].a);
        void'(rq.pop_front());
      end else begin
        chk("ram_ren", ram_ren, 0);
      end

      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        chk("fifo_wrreq", fifo_wrreq, 32'd1 << (bq[0].b % 16));
        chk("fifo_data", fifo_data, bq[0].a);
        chk("fifo_last", fifo_last, bq[0].b / 16);
        void'(bq.pop_front());
      end else begin
        chk("fifo_wrreq", fifo_wrreq, 0);
        chk("fifo_last", fifo_last, 0);
      end

      e = 0;
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        e = 32'd1 << dq[0].a;
        void'(dq.pop_front());
      end
      chk("done", done, e);
      chk("busy", busy, (cyc >= busy_lo && cyc < busy_hi) ? 1 : 0);

      if (rst) begin
        gq.delete(); rq.delete(); bq.delete(); dq.delete();
        rr = 0; idle_from = cyc + 1; busy_hi = 0; exp_cur = 0;
      end else if (cyc >= idle_from && req_valid != '0) begin
        found = 0;
        g = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_valid[(rr + i) % NREQ]) begin
            found = 1;
            g = (rr + i) % NREQ;
          end
        end
        base = int'(req_addr[g*AW +: AW]);
        len  = int'(req_len[g*AW +: AW]);
        gc   = cyc + 1;
        gq.push_back('{gc, g, 0});
        for (int k = 0; k < len; k++) begin
          rq.push_back('{gc + 1 + k, (base + k) % 256, 0});
          bq.push_back('{gc + 2 + k + RD_LAT, int'(mem[(base + k) % 256]),
                         ((k == len - 1) ? 16 : 0) + g});
        end
        dc = (len > 0) ? gc + len + RD_LAT + 2 : gc + 1;
        dq.push_back('{dc, g, 0});
        idle_from = dc;
        busy_lo = gc;
        busy_hi = dc;
        rr = (g + 1) % NREQ;
      end
    end
  end

  task automatic post(input int i, input int a, input int l);
    logic [31:0] av, lv;
    av = a;
    lv = l;
    req_addr[i*AW +: AW] = av[AW-1:0];
    req_len[i*AW +: AW]  = lv[AW-1:0];
    req_valid[i] = 1'b1;
  endtask

  // Advance one cycle; a requester drops its request once granted.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) req_valid[i] = 1'b0;
  endtask

  int nren;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    repeat (3) tick();
    rst = 1'b0;

    post(1, 'h10, 3);
    repeat (20) tick();
    post(3, 'hFE, 4);
    repeat (20) tick();
    post(2, 'h33, 0);
    repeat (8) tick();

    // All four held high: grants must rotate.
    for (int i = 0; i < NREQ; i++) post(i, 'h20 + i, 1);
    repeat (40) begin
      tick();
      for (int i = 0; i < NREQ; i++) if (!req_valid[i]) post(i, 'h20 + i, 1);
    end
    req_valid = '0;
    repeat (12) tick();

    // Reset after two of five reads.
    post(1, 'h40, 5);
    nren = 0;
    for (int w = 0; w < 50 && nren < 2; w++) begin
      tick();
      if (ram_ren) nren++;
    end
    chk("reset_setup_reads", nren, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    post(2, 'h80, 2);
    post(3, 'h90, 2);
    repeat (30) tick();

    repeat (1500) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 400) == 0) rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0)
          post(i, $urandom_range(0, 255), $urandom_range(0, 6));
        else if (req_valid[i] && $urandom_range(0, 40) == 0)
          req_valid[i] = 1'b0;
      end
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (40) tick();
    chk("leftover_events", gq.size() + rq.size() + bq.size() + dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
